// File: rtl/ripple_cnt_monitor.sv
// Brings an asynchronously settling ripple-counter value into the clk domain.
// Settled values are published on a valid/ready port, with wrap, skip, match and overrun flags.
module ripple_cnt_monitor #(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      SYNC_STAGES   = 2,
  parameter int unsigned      STABLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_REF     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             cmp_en,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             wrap_pulse,
  output logic             skip_pulse,
  output logic             match_pulse,
  output logic             overrun
);

  localparam int unsigned     StabW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {StTrack, StSettle} state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_inc;
  logic [StabW-1:0] stab_q;
  state_e           state_q;
  logic             stable_done;
  logic             accept;

  // Per-bit synchroniser; multi-bit skew is absorbed by the stability filter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_REF;
    end else begin
      sync_q[0] <= cnt_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    s           = sync_q[SYNC_STAGES-1];
    acc_inc     = acc_q + 1'b1;
    stable_done = (state_q == StSettle) && (s == cand_q) && (stab_q >= StabLast);
    accept      = stable_done && (cand_q != acc_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StTrack;
      cand_q      <= RESET_REF;
      acc_q       <= RESET_REF;
      stab_q      <= '0;
      cnt_out     <= RESET_REF;
      cnt_valid   <= 1'b0;
      wrap_pulse  <= 1'b0;
      skip_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      wrap_pulse  <= 1'b0;
      skip_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      if (cnt_valid && cnt_ready) cnt_valid <= 1'b0;
      if (overrun_clr) overrun <= 1'b0;

      if (s != cand_q) begin
        cand_q  <= s;
        stab_q  <= StabW'(1);
        state_q <= StSettle;
      end else if (stable_done) begin
        state_q <= StTrack;
      end else if (state_q == StSettle) begin
        stab_q <= stab_q + 1'b1;
      end

      // Later assignments here override the handshake drop and overrun clear above.
      if (accept) begin
        acc_q       <= cand_q;
        cnt_out     <= cand_q;
        cnt_valid   <= 1'b1;
        wrap_pulse  <= (cand_q < acc_q);
        skip_pulse  <= (cand_q != acc_inc);
        match_pulse <= cmp_en && (cand_q == cmp_val);
        if (cnt_valid && !cnt_ready) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ripple_cnt_monitor.sv
// Directed bench for ripple_cnt_monitor: reset, latency, glitch rejection, overrun,
// compare match, wrap/skip and asynchronous reset.
module tb_ripple_cnt_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] cnt_in;
  logic [3:0] cmp_val;
  logic       cmp_en;
  logic       overrun_clr;
  logic [3:0] cnt_out;
  logic       cnt_valid;
  logic       cnt_ready;
  logic       wrap_pulse;
  logic       skip_pulse;
  logic       match_pulse;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  ripple_cnt_monitor dut (
    .clk        (clk),
    .rstn       (rstn),
    .cnt_in     (cnt_in),
    .cmp_val    (cmp_val),
    .cmp_en     (cmp_en),
    .overrun_clr(overrun_clr),
    .cnt_out    (cnt_out),
    .cnt_valid  (cnt_valid),
    .cnt_ready  (cnt_ready),
    .wrap_pulse (wrap_pulse),
    .skip_pulse (skip_pulse),
    .match_pulse(match_pulse),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rstn = 1'b0; cnt_in = 4'hF; cmp_val = 4'h0; cmp_en = 1'b0;
    overrun_clr = 1'b0; cnt_ready = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (cnt_out !== 4'hF) begin n_fail++; $display("FAIL reset_cnt_out: got %h want F", cnt_out); end
    n_checks++; if (cnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cnt_valid); end
    n_checks++; if ({wrap_pulse, skip_pulse, match_pulse} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {wrap_pulse, skip_pulse, match_pulse}); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_latency_wrap();
    cnt_in = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (cnt_out !== 4'hF || cnt_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: got out=%h valid=%b want out=F valid=0", cnt_out, cnt_valid); end
    @(negedge clk);
    n_checks++; if (cnt_out !== 4'h0 || cnt_valid !== 1'b1) begin n_fail++; $display("FAIL lat_accept: got out=%h valid=%b want out=0 valid=1", cnt_out, cnt_valid); end
    n_checks++; if (wrap_pulse !== 1'b1 || skip_pulse !== 1'b0) begin n_fail++; $display("FAIL lat_wrap_skip: got wrap=%b skip=%b want wrap=1 skip=0", wrap_pulse, skip_pulse); end
    @(negedge clk);
    n_checks++; if (cnt_valid !== 1'b0 || wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL lat_drop: got valid=%b wrap=%b want valid=0 wrap=0", cnt_valid, wrap_pulse); end
  endtask

  task automatic test_glitch();
    cnt_in = 4'h3;
    repeat (6) @(negedge clk);
    n_checks++; if (cnt_out !== 4'h3) begin n_fail++; $display("FAIL glitch_pre: got %h want 3", cnt_out); end
    cnt_in = 4'h7;
    @(negedge clk);
    cnt_in = 4'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (cnt_out !== 4'h3) begin n_fail++; $display("FAIL glitch_hold%0d: got %h want 3", i, cnt_out); end
    end
    @(negedge clk);
    n_checks++; if (cnt_out !== 4'h4 || cnt_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_accept: got out=%h valid=%b want out=4 valid=1", cnt_out, cnt_valid); end
    n_checks++; if (skip_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL glitch_flags: got skip=%b wrap=%b want 0 0", skip_pulse, wrap_pulse); end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    cnt_ready = 1'b0;
    cnt_in = 4'h1;
    repeat (6) @(negedge clk);
    n_checks++; if (cnt_out !== 4'h1 || cnt_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got out=%h valid=%b ovr=%b want 1 1 0", cnt_out, cnt_valid, overrun); end
    cnt_in = 4'h2;
    repeat (6) @(negedge clk);
    n_checks++; if (cnt_out !== 4'h2 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_second: got out=%h ovr=%b want 2 1", cnt_out, overrun); end
    cnt_in = 4'h3;
    repeat (6) @(negedge clk);
    n_checks++; if (cnt_out !== 4'h3 || cnt_valid !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_third: got out=%h valid=%b ovr=%b want 3 1 1", cnt_out, cnt_valid, overrun); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    cnt_in = 4'h4;
    repeat (3) @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++; if (overrun !== 1'b1 || cnt_out !== 4'h4) begin n_fail++; $display("FAIL ovr_set_wins: got ovr=%b out=%h want 1 4", overrun, cnt_out); end
  endtask

  task automatic test_match_wrap();
    cnt_ready = 1'b1; cmp_val = 4'h5; cmp_en = 1'b1;
    cnt_in = 4'h5;
    repeat (4) @(negedge clk);
    n_checks++; if (cnt_out !== 4'h5 || match_pulse !== 1'b1) begin n_fail++; $display("FAIL match_hit: got out=%h match=%b want 5 1", cnt_out, match_pulse); end
    n_checks++; if (skip_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL match_flags: got skip=%b wrap=%b want 0 0", skip_pulse, wrap_pulse); end
    @(negedge clk);
    n_checks++; if (match_pulse !== 1'b0 || cnt_valid !== 1'b0) begin n_fail++; $display("FAIL match_one_cycle: got match=%b valid=%b want 0 0", match_pulse, cnt_valid); end
    cmp_en = 1'b0;
    cnt_in = 4'h6;
    repeat (6) @(negedge clk);
    cnt_in = 4'h5;
    repeat (4) @(negedge clk);
    n_checks++; if (cnt_out !== 4'h5 || match_pulse !== 1'b0) begin n_fail++; $display("FAIL match_disabled: got out=%h match=%b want 5 0", cnt_out, match_pulse); end
    n_checks++; if (wrap_pulse !== 1'b1 || skip_pulse !== 1'b1) begin n_fail++; $display("FAIL down_step: got wrap=%b skip=%b want 1 1", wrap_pulse, skip_pulse); end
    repeat (2) @(negedge clk);
    cnt_in = 4'hE;
    repeat (4) @(negedge clk);
    n_checks++; if (cnt_out !== 4'hE || wrap_pulse !== 1'b0 || skip_pulse !== 1'b1) begin n_fail++; $display("FAIL jump_up: got out=%h wrap=%b skip=%b want E 0 1", cnt_out, wrap_pulse, skip_pulse); end
    repeat (2) @(negedge clk);
    cnt_in = 4'h1;
    repeat (4) @(negedge clk);
    n_checks++; if (cnt_out !== 4'h1 || wrap_pulse !== 1'b1 || skip_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_skip: got out=%h wrap=%b skip=%b want 1 1 1", cnt_out, wrap_pulse, skip_pulse); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    cnt_ready = 1'b0;
    cnt_in = 4'h7;
    repeat (6) @(negedge clk);
    n_checks++; if (cnt_out !== 4'h7 || cnt_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got out=%h valid=%b want 7 1", cnt_out, cnt_valid); end
    cnt_in = 4'h8;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (cnt_out !== 4'hF || cnt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_immediate: got out=%h valid=%b want F 0", cnt_out, cnt_valid); end
    n_checks++; if ({wrap_pulse, skip_pulse, match_pulse, overrun} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {wrap_pulse, skip_pulse, match_pulse, overrun}); end
    @(negedge clk);
    rstn = 1'b1;
    cnt_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (cnt_out !== 4'hF || cnt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_early: got out=%h valid=%b want F 0", cnt_out, cnt_valid); end
    @(negedge clk);
    n_checks++; if (cnt_out !== 4'h8 || cnt_valid !== 1'b1) begin n_fail++; $display("FAIL rst_accept: got out=%h valid=%b want 8 1", cnt_out, cnt_valid); end
    n_checks++; if (wrap_pulse !== 1'b1 || skip_pulse !== 1'b1) begin n_fail++; $display("FAIL rst_flags_after: got wrap=%b skip=%b want 1 1", wrap_pulse, skip_pulse); end
  endtask

  initial begin
    test_reset();
    test_latency_wrap();
    test_glitch();
    test_overrun();
    test_match_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
